// File: rtl/hps_onchip_mem_pkg.sv
// Shared types and defaults for the on-chip RAM <-> Avalon-ST streamer.
package hps_onchip_mem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 11;
  localparam int LEN_W_DEF  = 12;

  localparam logic [1:0] BE_ALL = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_RUN = 2'd1,
    WR_RUN = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/hps_onchip_mem_rdfifo.sv
// Read-return FIFO: absorbs RAM read data while the stream sink back-pressures.
module hps_onchip_mem_rdfifo
  import hps_onchip_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4,
  parameter int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] head,
  output logic [CW-1:0]     count,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/hps_onchip_mem_streamer.sv
// Avalon-MM master for the 2048x16 on-chip RAM that streams a block out (read)
// or fills a block from an incoming stream (write), under start/done control.
module hps_onchip_mem_streamer
  import hps_onchip_mem_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              dir,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [1:0]        mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_sop,
  output logic              src_eop,
  input  logic [DATA_W-1:0] snk_data,
  input  logic              snk_valid,
  output logic              snk_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [LEN_W-1:0]  len_q, issue_cnt, beat_cnt;
  logic              rd_pending;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic [CW:0]       occupancy;
  logic              issue, accept, pop, last_pop, last_write, kill;

  // In-flight reads count against FIFO space so a return always has a slot.
  assign occupancy  = {1'b0, fifo_count} + {{CW{1'b0}}, rd_pending};
  assign kill       = abort && (state != IDLE);
  assign issue      = (state == RD_RUN) && (issue_cnt < len_q) && (occupancy < DEPTH_V);
  assign accept     = (state == WR_RUN) && snk_valid;
  assign pop        = (state == RD_RUN) && !fifo_empty && src_ready;
  assign last_pop   = pop && (beat_cnt == len_q - LEN_W'(1));
  assign last_write = accept && (issue_cnt == len_q - LEN_W'(1));

  hps_onchip_mem_rdfifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH),
    .CW     (CW)
  ) u_rdfifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (rd_pending),
    .push_data (mem_readdata),
    .pop       (pop),
    .flush     (kill),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (length == '0) state_nxt = FINISH;
          else              state_nxt = dir ? WR_RUN : RD_RUN;
        end
      end
      RD_RUN: begin
        if (kill)          state_nxt = IDLE;
        else if (last_pop) state_nxt = FINISH;
      end
      WR_RUN: begin
        if (kill)            state_nxt = IDLE;
        else if (last_write) state_nxt = FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state != IDLE);
    done           = (state == FINISH) && !abort;
    mem_chipselect = issue || accept;
    mem_write      = accept;
    mem_address    = (issue || accept) ? ptr : '0;
    mem_writedata  = accept ? snk_data : '0;
    snk_ready      = (state == WR_RUN);
    src_valid      = (state == RD_RUN) && !fifo_empty;
    src_data       = src_valid ? fifo_head : '0;
    src_sop        = src_valid && (beat_cnt == '0);
    src_eop        = src_valid && (beat_cnt == len_q - LEN_W'(1));
  end

  assign mem_byteenable = BE_ALL;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr        <= '0;
      len_q      <= '0;
      issue_cnt  <= '0;
      beat_cnt   <= '0;
      rd_pending <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        ptr       <= base_addr;
        len_q     <= length;
        issue_cnt <= '0;
        beat_cnt  <= '0;
      end else begin
        if (issue || accept) begin
          ptr       <= ptr + ADDR_W'(1);
          issue_cnt <= issue_cnt + LEN_W'(1);
        end
        if (pop) beat_cnt <= beat_cnt + LEN_W'(1);
      end
      rd_pending <= issue && !kill;
    end
  end

endmodule

// File: tb/tb_hps_onchip_mem_streamer.sv
// Bench for hps_onchip_mem_streamer: RAM model, beat/address/write scoreboards.
module tb_hps_onchip_mem_streamer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, dir, abort;
  logic [10:0] base_addr;
  logic [11:0] length;
  logic        busy, done;
  logic [10:0] mem_address;
  logic        mem_chipselect, mem_write;
  logic [1:0]  mem_byteenable;
  logic [15:0] mem_writedata, mem_readdata;
  logic [15:0] src_data, snk_data;
  logic        src_valid, src_ready, src_sop, src_eop;
  logic        snk_valid, snk_ready;

  hps_onchip_mem_streamer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .dir            (dir),
    .base_addr      (base_addr),
    .length         (length),
    .abort          (abort),
    .busy           (busy),
    .done           (done),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_byteenable (mem_byteenable),
    .mem_writedata  (mem_writedata),
    .mem_readdata   (mem_readdata),
    .src_data       (src_data),
    .src_valid      (src_valid),
    .src_ready      (src_ready),
    .src_sop        (src_sop),
    .src_eop        (src_eop),
    .snk_data       (snk_data),
    .snk_valid      (snk_valid),
    .snk_ready      (snk_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [15:0] data; logic sop; logic eop;} beat_t;
  typedef struct packed {logic [10:0] a; logic [15:0] d;} wr_t;
  typedef struct {
    logic [10:0] base;
    logic [11:0] len;
    int          mode;
    int          exp_first_lat;
    int          exp_done_gap;
  } rd_vec_t;

  logic [15:0] ram   [2048];
  logic [15:0] model [2048];
  beat_t       sb_q[$];
  logic [10:0] addr_q[$];
  wr_t         wr_q[$];

  int errors = 0, checks = 0;
  int cyc = 0, rdy_mode = 0;
  int beats_seen = 0, cs_cnt = 0, done_cnt = 0, wr_cnt = 0;
  int done_cyc = -1, first_sop_cyc = -1, last_eop_cyc = -1, max_cnt = 0;

  // RAM model; preloaded addr=data while in reset
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 2048; i++) ram[i] <= i[15:0];
    end else begin
      if (mem_chipselect && mem_write)  ram[mem_address] <= mem_writedata;
      if (mem_chipselect && !mem_write) mem_readdata <= ram[mem_address];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) src_ready = 1'b1;
      else               src_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
    end
  end

  // Monitor: compares every stream beat, read address and write against the queues
  initial begin
    beat_t e;
    wr_t   w;
    logic [10:0] a;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (int'(dut.fifo_count) > max_cnt) max_cnt = int'(dut.fifo_count);
        if (src_valid && src_ready) begin
          if (sb_q.size() == 0) check(1'b0, "extra_beat", src_data, 0);
          else begin
            e = sb_q.pop_front();
            check(src_data == e.data, "beat_data", src_data, e.data);
            check({src_sop, src_eop} == {e.sop, e.eop}, "sop_eop", {src_sop, src_eop}, {e.sop, e.eop});
          end
          beats_seen++;
          if (src_sop) first_sop_cyc = cyc;
          if (src_eop) last_eop_cyc = cyc;
        end
        if (mem_chipselect && !mem_write) begin
          if (addr_q.size() == 0) check(1'b0, "extra_read", mem_address, 0);
          else begin
            a = addr_q.pop_front();
            check(mem_address == a, "rd_addr", mem_address, a);
          end
        end
        if (mem_chipselect && mem_write) begin
          wr_cnt++;
          if (wr_q.size() == 0) check(1'b0, "extra_write", mem_writedata, 0);
          else begin
            w = wr_q.pop_front();
            check({mem_address, mem_writedata} == {w.a, w.d}, "wr_addr_data",
                  {mem_address, mem_writedata}, {w.a, w.d});
          end
        end
        if (mem_chipselect) cs_cnt++;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  task automatic wait_done(input int bound);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < bound) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(done_cnt == d0 + 1, "done_seen", done_cnt - d0, 1);
  endtask

  task automatic start_xfer(input logic d, input logic [10:0] b, input logic [11:0] l,
                            output int sc);
    @(posedge clk);
    #1;
    start = 1'b1; dir = d; base_addr = b; length = l;
    sc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic push_read(input logic [10:0] base, input logic [11:0] len);
    logic [10:0] a;
    for (int i = 0; i < int'(len); i++) begin
      a = base + i[10:0];
      sb_q.push_back(beat_t'{model[a], i == 0, i == int'(len) - 1});
      addr_q.push_back(a);
    end
  endtask

  task automatic run_read(input rd_vec_t v);
    int sc;
    rdy_mode = v.mode;
    push_read(v.base, v.len);
    first_sop_cyc = -1;
    last_eop_cyc  = -1;
    start_xfer(1'b0, v.base, v.len, sc);
    wait_done(400);
    check(sb_q.size() == 0, "beats_left", sb_q.size(), 0);
    check(addr_q.size() == 0, "reads_left", addr_q.size(), 0);
    check(done_cyc == last_eop_cyc + v.exp_done_gap, "done_gap", done_cyc - last_eop_cyc, v.exp_done_gap);
    if (v.exp_first_lat >= 0)
      check(first_sop_cyc == sc + v.exp_first_lat, "first_lat", first_sop_cyc - sc, v.exp_first_lat);
    rdy_mode = 0;
  endtask

  rd_vec_t vecs [4];

  initial begin
    int sc, c0, d0, n;
    logic        wv [8] = '{0, 1, 0, 1, 1, 1, 1, 0};
    logic [15:0] wd [8] = '{16'h0, 16'hAAAA, 16'h0, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hDDDD, 16'h0};

    vecs[0] = '{11'h010, 12'd5, 0, 3, 1};
    vecs[1] = '{11'h7FE, 12'd4, 0, 3, 1};
    vecs[2] = '{11'h040, 12'd8, 1, -1, 1};
    vecs[3] = '{11'h123, 12'd1, 0, 3, 1};

    for (int i = 0; i < 2048; i++) model[i] = i[15:0];
    reset_n = 1'b0; start = 1'b0; dir = 1'b0; abort = 1'b0;
    base_addr = '0; length = '0; snk_data = '0; snk_valid = 1'b0; src_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check(busy == 1'b0, "rst_busy", busy, 0);
    check(done == 1'b0, "rst_done", done, 0);
    check({mem_chipselect, mem_write} == 2'b00, "rst_cs_wr", {mem_chipselect, mem_write}, 0);
    check(mem_byteenable == 2'b11, "rst_be", mem_byteenable, 3);
    check(mem_address == 11'h0, "rst_addr", mem_address, 0);
    check({src_valid, src_sop, src_eop, snk_ready} == 4'b0, "rst_stream",
          {src_valid, src_sop, src_eop, snk_ready}, 0);
    check(src_data == 16'h0 && mem_writedata == 16'h0, "rst_data", src_data, 0);

    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 4; i++) run_read(vecs[i]);

    // zero-length start: done next cycle, no RAM access
    c0 = cs_cnt;
    start_xfer(1'b0, 11'h050, 12'd0, sc);
    wait_done(10);
    check(done_cyc == sc + 1, "len0_done", done_cyc - sc, 1);
    check(cs_cnt == c0, "len0_no_cs", cs_cnt - c0, 0);

    // write with gaps; fourth offered beat must be refused
    wr_q.push_back(wr_t'{11'h100, 16'hAAAA});
    wr_q.push_back(wr_t'{11'h101, 16'hBBBB});
    wr_q.push_back(wr_t'{11'h102, 16'hCCCC});
    wr_cnt = 0;
    d0 = done_cnt;
    start_xfer(1'b1, 11'h100, 12'd3, sc);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      snk_valid = wv[i];
      snk_data  = wd[i];
      if (i == 5) begin
        @(negedge clk);
        check(snk_ready == 1'b0, "wr_ready_drop", snk_ready, 0);
      end
    end
    @(posedge clk);
    #1;
    snk_valid = 1'b0;
    repeat (2) @(posedge clk);
    check(done_cnt == d0 + 1, "wr_done", done_cnt - d0, 1);
    check(wr_cnt == 3, "wr_count", wr_cnt, 3);
    check(ram[11'h100] == 16'hAAAA, "ram_100", ram[11'h100], 16'hAAAA);
    check(ram[11'h101] == 16'hBBBB, "ram_101", ram[11'h101], 16'hBBBB);
    check(ram[11'h102] == 16'hCCCC, "ram_102", ram[11'h102], 16'hCCCC);
    check(ram[11'h103] == 16'h0103, "ram_103", ram[11'h103], 16'h0103);
    model[11'h100] = 16'hAAAA;
    model[11'h101] = 16'hBBBB;
    model[11'h102] = 16'hCCCC;
    run_read('{11'h0FF, 12'd5, 0, 3, 1});

    // abort on the third beat of a 16-word read
    push_read(11'h200, 12'd16);
    beats_seen = 0;
    start_xfer(1'b0, 11'h200, 12'd16, sc);
    n = 0;
    while (beats_seen < 2 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(beats_seen == 2, "abort_sync", beats_seen, 2);
    d0 = done_cnt;
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    #1;
    check(busy == 1'b0, "abort_busy", busy, 0);
    check(mem_chipselect == 1'b0, "abort_cs", mem_chipselect, 0);
    check(beats_seen == 3, "abort_beats", beats_seen, 3);
    sb_q.delete();
    addr_q.delete();
    c0 = cs_cnt;
    repeat (10) @(negedge clk);
    check(cs_cnt == c0, "cs_after_abort", cs_cnt - c0, 0);
    check(done_cnt == d0, "no_done_abort", done_cnt - d0, 0);
    run_read('{11'h030, 12'd2, 0, 3, 1});

    check(max_cnt <= 4, "fifo_max", max_cnt, 4);
    check(max_cnt == 4, "fifo_filled", max_cnt, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
